// File: rtl/clint_timer_pkg.sv
// Shared definitions for the CLINT timer block.
//   - Register offsets within the 64 KiB CLINT window
//   - Handshake FSM state encoding
package clint_timer_pkg;

    localparam logic [15:0] CLINT_OFF_MSIP      = 16'h0000;
    localparam logic [15:0] CLINT_OFF_MTIMECMP  = 16'h4000;
    localparam logic [15:0] CLINT_OFF_MTIMECMPH = 16'h4004;
    localparam logic [15:0] CLINT_OFF_MTIME     = 16'hBFF8;
    localparam logic [15:0] CLINT_OFF_MTIMEH    = 16'hBFFC;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } clint_state_e;

endpackage

// File: rtl/clint_prescaler.sv
// Microsecond timebase: divides clk by FMAX_MHz.
//   clk   in  clock
//   reset in  synchronous active-high reset
//   tick  out one-cycle pulse each time the counter wraps (once per us)
module clint_prescaler #(
    parameter int FMAX_MHz = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == W'(FMAX_MHz - 1));
    assign cnt_d = tick ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_timer.sv
// CLINT subset: mtime / mtimecmp / msip behind a single-outstanding
// request/response port, producing the MTIP and MSIP interrupt levels.
//   clk, reset               clock, synchronous active-high reset
//   req_valid/ready/wen/addr/wdata   request channel (ready only in S_IDLE)
//   resp_valid/ready/rdata   response channel, held until resp_ready
//   mtime                    live mtime for the time/timeh CSRs
//   timer_irq, soft_irq      registered MTIP / MSIP levels
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int          FMAX_MHz  = 27,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [63:0] mtime,
    output logic        timer_irq,
    output logic        soft_irq
);

    clint_state_e state_q, state_d;
    logic [63:0]  mtime_q, mtime_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    logic         msip_q, msip_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         timer_irq_q, soft_irq_q;
    logic         tick;
    logic         accept, in_win, wr;
    logic [15:0]  off;
    logic [31:0]  rd_val;

    clint_prescaler #(.FMAX_MHz(FMAX_MHz)) u_presc (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign accept = req_valid && (state_q == S_IDLE);
    assign in_win = (req_addr[31:16] == BASE_ADDR[31:16]);
    assign off    = req_addr[15:0];
    assign wr     = accept && req_wen && in_win;

    // Read mux on current register values, i.e. before any same-cycle tick.
    always_comb begin
        rd_val = '0;
        if (in_win) begin
            case (off)
                CLINT_OFF_MSIP:      rd_val = {31'b0, msip_q};
                CLINT_OFF_MTIMECMP:  rd_val = mtimecmp_q[31:0];
                CLINT_OFF_MTIMECMPH: rd_val = mtimecmp_q[63:32];
                CLINT_OFF_MTIME:     rd_val = mtime_q[31:0];
                CLINT_OFF_MTIMEH:    rd_val = mtime_q[63:32];
                default:             rd_val = '0;
            endcase
        end
    end

    // Register write / tick datapath. A write to either mtime half replaces
    // the tick for that cycle, so the other half never sees a carry.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr) begin
            case (off)
                CLINT_OFF_MSIP:      msip_d             = req_wdata[0];
                CLINT_OFF_MTIMECMP:  mtimecmp_d[31:0]   = req_wdata;
                CLINT_OFF_MTIMECMPH: mtimecmp_d[63:32]  = req_wdata;
                CLINT_OFF_MTIME:     mtime_d            = {mtime_q[63:32], req_wdata};
                CLINT_OFF_MTIMEH:    mtime_d            = {req_wdata, mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    assign rdata_d = accept ? (req_wen ? 32'd0 : rd_val) : rdata_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)  state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            rdata_q     <= '0;
            timer_irq_q <= 1'b0;
            soft_irq_q  <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            rdata_q     <= rdata_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
            soft_irq_q  <= msip_q;
        end
    end

    assign resp_rdata = rdata_q;
    assign mtime      = mtime_q;
    assign timer_irq  = timer_irq_q;
    assign soft_irq   = soft_irq_q;

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;

    localparam int          FMAX = 27;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [63:0] mtime;
    logic        timer_irq, soft_irq;

    int checks = 0;
    int errors = 0;

    clint_timer #(.FMAX_MHz(FMAX), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .mtime      (mtime),
        .timer_irq  (timer_irq),
        .soft_irq   (soft_irq)
    );

    always #5 clk = ~clk;

    // Single access: accept edge, then one response cycle with resp_ready=1.
    // Returns the response valid flag and data seen after the accept edge.
    task automatic bus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic vld, output logic [31:0] rdata);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        vld   = resp_valid;
        rdata = resp_rdata;
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mtime !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: resp_valid=%b req_ready=%b mtime=%h want 0/1/0",
                     resp_valid, req_ready, mtime);
        end
        reset = 1'b0;
        repeat (3 * FMAX) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mtime !== 64'd3 || timer_irq !== 1'b0 || soft_irq !== 1'b0) begin
            errors++;
            $display("FAIL idle_ticks: mtime=%0d tirq=%b sirq=%b want 3/0/0",
                     mtime, timer_irq, soft_irq);
        end
    endtask

    task automatic test_timer();
        logic v; logic [31:0] d;
        bit found = 0;
        bus(1'b1, BASE + 32'h4000, 32'd5, v, d);
        bus(1'b1, BASE + 32'h4004, 32'd0, v, d);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL irq_before: got %b want 0", timer_irq);
        end
        for (int i = 0; i < 4 * FMAX; i++) begin
            @(posedge clk); @(negedge clk);
            if (mtime == 64'd5) begin found = 1; break; end
        end
        checks++;
        if (!found || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_reach5: found=%0d irq=%b want 1/0", found, timer_irq);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise: got %b want 1", timer_irq);
        end
        // Raise mtimecmp hi: compare changes at accept edge, irq falls one edge later.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 32'h4004; req_wdata = 32'd1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++; $display("FAIL irq_hold_at_accept: got %b want 1", timer_irq);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL irq_fall: got %b want 0", timer_irq);
        end
    endtask

    task automatic test_wrap();
        logic v; logic [31:0] d;
        bit found = 0;
        bus(1'b1, BASE + 32'h4000, 32'd0, v, d);
        bus(1'b1, BASE + 32'h4004, 32'd0, v, d);
        // Hi first, so a tick between the two writes only bumps the low half.
        bus(1'b1, BASE + 32'hBFFC, 32'hFFFF_FFFF, v, d);
        bus(1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, v, d);
        checks++;
        if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL mtime_write: got %h want all-ones", mtime);
        end
        for (int i = 0; i < 2 * FMAX; i++) begin
            @(posedge clk); @(negedge clk);
            if (mtime != 64'hFFFF_FFFF_FFFF_FFFF) begin found = 1; break; end
        end
        checks++;
        if (!found || mtime !== 64'd0) begin
            errors++; $display("FAIL mtime_wrap: found=%0d mtime=%h want 1/0", found, mtime);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++; $display("FAIL irq_after_wrap: got %b want 1", timer_irq);
        end
    endtask

    task automatic test_msip();
        logic v; logic [31:0] d;
        bus(1'b1, BASE, 32'hFFFF_FFFF, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++; $display("FAIL write_resp: vld=%b rdata=%h want 1/0", v, d);
        end
        bus(1'b0, BASE, 32'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd1 || soft_irq !== 1'b1) begin
            errors++; $display("FAIL msip_read: vld=%b rdata=%h sirq=%b want 1/1/1", v, d, soft_irq);
        end
        bus(1'b1, BASE, 32'd0, v, d);
        checks++;
        if (soft_irq !== 1'b0) begin
            errors++; $display("FAIL msip_clear: sirq=%b want 0", soft_irq);
        end
    endtask

    task automatic test_hold();
        logic v; logic [31:0] d;
        bus(1'b1, BASE + 32'h4000, 32'hA5A5_0000, v, d);
        bus(1'b1, BASE + 32'h4004, 32'h0000_0077, v, d);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 32'h4000; req_wdata = 32'd0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; req_addr = BASE + 32'h4004;
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_0000 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: vld=%b rdata=%h rdy=%b want 1/a5a50000/0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            @(posedge clk); @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: vld=%b rdy=%b want 0/1", resp_valid, req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0077) begin
            errors++; $display("FAIL pending_req: vld=%b rdata=%h want 1/77", resp_valid, resp_rdata);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        logic v; logic [31:0] d, lo, hi, ms;
        bus(1'b0, BASE + 32'h1234, 32'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++; $display("FAIL unmapped_read: vld=%b rdata=%h want 1/0", v, d);
        end
        bus(1'b1, BASE + 32'h1234, 32'hDEAD_BEEF, v, d);
        bus(1'b0, BASE, 32'd0, v, ms);
        bus(1'b0, BASE + 32'h4000, 32'd0, v, lo);
        bus(1'b0, BASE + 32'h4004, 32'd0, v, hi);
        checks++;
        if (ms !== 32'd0 || lo !== 32'hA5A5_0000 || hi !== 32'h0000_0077) begin
            errors++;
            $display("FAIL unmapped_write: msip=%h cmplo=%h cmphi=%h want 0/a5a50000/77", ms, lo, hi);
        end
    endtask

    task automatic test_reset_mid();
        bus_start();
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++; $display("FAIL mid_resp: vld=%b want 1", resp_valid);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mtime !== 64'd0 ||
            resp_rdata !== 32'd0 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: vld=%b rdy=%b mtime=%h rdata=%h tirq=%b want 0/1/0/0/0",
                     resp_valid, req_ready, mtime, resp_rdata, timer_irq);
        end
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic bus_start();
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 32'h4000; req_wdata = 32'd0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_timer();
        test_wrap();
        test_msip();
        test_hold();
        test_unmapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
